// File: rtl/cache_pkg.sv
// Shared geometry, metadata layout and FSM state encoding for the
// 2-way, 8-set, one-byte-per-line cache controller.
package cache_pkg;

  localparam int TAG_W    = 5;
  localparam int INDEX_W  = 3;
  localparam int NUM_SETS = 8;
  localparam int NUM_WAYS = 2;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    WRITEBACK,
    FILL,
    RESPOND
  } state_e;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic             valid;
    logic             dirty;
  } line_meta_t;

endpackage

// File: rtl/cache_ctrl_if.sv
// CPU, data-array and memory signals of the cache controller in one bundle.
// slave = controller view, master = environment (CPU, data array, memory).
interface cache_ctrl_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);

  logic                         cpu_req;
  logic                         cpu_we;
  logic [ADDR_W-1:0]            cpu_addr;
  logic [DATA_W-1:0]            cpu_wdata;
  logic                         cpu_ready;
  logic                         cpu_ack;
  logic [DATA_W-1:0]            cpu_rdata;

  logic [cache_pkg::INDEX_W-1:0] da_index;
  logic                         da_way;
  logic                         da_we;
  logic [DATA_W-1:0]            da_wdata;
  logic [DATA_W-1:0]            da_rdata;

  logic                         mem_req;
  logic                         mem_we;
  logic [ADDR_W-1:0]            mem_addr;
  logic [DATA_W-1:0]            mem_wdata;
  logic [DATA_W-1:0]            mem_rdata;
  logic                         mem_ack;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, da_rdata, mem_rdata, mem_ack,
    output cpu_ready, cpu_ack, cpu_rdata, da_index, da_way, da_we, da_wdata,
           mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, da_rdata, mem_rdata, mem_ack,
    input  cpu_ready, cpu_ack, cpu_rdata, da_index, da_way, da_we, da_wdata,
           mem_req, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/cache_meta.sv
// Tag/valid/dirty storage per set and way plus the per-set lru bit.
// Reads are combinational; writes and lru updates land on the clock edge.
module cache_meta
  import cache_pkg::*;
(
  input  logic                        clock,
  input  logic                        reset,
  input  logic [INDEX_W-1:0]          rd_index,
  output line_meta_t [NUM_WAYS-1:0]   rd_meta,
  output logic                        rd_lru,
  input  logic                        wr_en,
  input  logic [INDEX_W-1:0]          wr_index,
  input  logic                        wr_way,
  input  line_meta_t                  wr_meta,
  input  logic                        lru_en,
  input  logic [INDEX_W-1:0]          lru_index,
  input  logic                        lru_way
);

  logic [TAG_W-1:0]                   tag_q [NUM_SETS][NUM_WAYS];
  logic [NUM_SETS-1:0][NUM_WAYS-1:0]  valid_q, valid_d;
  logic [NUM_SETS-1:0][NUM_WAYS-1:0]  dirty_q, dirty_d;
  logic [NUM_SETS-1:0]                lru_q, lru_d;

  always_comb begin
    // NOTE: every target gets a default first, so no path leaves it unassigned and no latch is inferred.
    valid_d = valid_q;
    dirty_d = dirty_q;
    lru_d   = lru_q;
    if (wr_en) begin
      valid_d[wr_index][wr_way] = wr_meta.valid;
      dirty_d[wr_index][wr_way] = wr_meta.dirty;
    end
    if (lru_en) begin
      lru_d[lru_index] = lru_way;
    end
  end

  always_ff @(posedge clock) begin
    // NOTE: non-blocking assignments here so every flop samples pre-edge values regardless of block order.
    if (reset) begin
      valid_q <= '0;
      dirty_q <= '0;
      lru_q   <= '0;
    end else begin
      valid_q <= valid_d;
      dirty_q <= dirty_d;
      lru_q   <= lru_d;
    end
  end

  // NOTE: the tag array is a plain memory with no reset; a cleared valid bit makes stale tags harmless.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      tag_q[wr_index][wr_way] <= wr_meta.tag;
    end
  end

  always_comb begin
    for (int w = 0; w < NUM_WAYS; w++) begin
      rd_meta[w].tag   = tag_q[rd_index][w];
      rd_meta[w].valid = valid_q[rd_index][w];
      rd_meta[w].dirty = dirty_q[rd_index][w];
    end
    rd_lru = lru_q[rd_index];
  end

endmodule

// File: rtl/cache_ctrl.sv
// Cache controller: request FSM, hit/miss detection, victim choice,
// writeback/fill sequencing and saturating hit/miss counters.
module cache_ctrl
  import cache_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic        clock,
  input  logic        reset,
  cache_ctrl_if.slave bus,
  output logic        hit,
  output logic        miss,
  output logic [7:0]  hit_count,
  output logic [7:0]  miss_count
);

  state_e              state_q, state_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                way_q, way_d;
  logic [7:0]          hit_cnt_q, hit_cnt_d;
  logic [7:0]          miss_cnt_q, miss_cnt_d;

  logic [TAG_W-1:0]          req_tag;
  logic [INDEX_W-1:0]        req_index;
  line_meta_t [NUM_WAYS-1:0] rd_meta;
  logic                      rd_lru;
  logic                      meta_we, meta_way;
  line_meta_t                meta_wdata;
  logic                      lru_we, lru_way;
  logic [NUM_WAYS-1:0]       way_match;
  logic                      lookup_hit, hit_way, victim_way, sel_way, victim_dirty;

  assign req_tag   = addr_q[ADDR_W-1 -: TAG_W];
  assign req_index = addr_q[INDEX_W-1:0];

  cache_meta u_meta (
    .clock     (clock),
    .reset     (reset),
    .rd_index  (req_index),
    .rd_meta   (rd_meta),
    .rd_lru    (rd_lru),
    .wr_en     (meta_we),
    .wr_index  (req_index),
    .wr_way    (meta_way),
    .wr_meta   (meta_wdata),
    .lru_en    (lru_we),
    .lru_index (req_index),
    .lru_way   (lru_way)
  );

  // Way 0 wins a double match; victim is the first invalid way, else the lru way.
  always_comb begin
    for (int w = 0; w < NUM_WAYS; w++) begin
      way_match[w] = rd_meta[w].valid && (rd_meta[w].tag == req_tag);
    end
    lookup_hit = |way_match;
    hit_way    = !way_match[0];
    if (!rd_meta[0].valid)      victim_way = 1'b0;
    else if (!rd_meta[1].valid) victim_way = 1'b1;
    else                        victim_way = rd_lru;
    victim_dirty = rd_meta[victim_way].valid && rd_meta[victim_way].dirty;
    sel_way      = lookup_hit ? hit_way : victim_way;
  end

  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    data_d     = data_q;
    way_d      = way_q;
    meta_we    = 1'b0;
    meta_way   = way_q;
    meta_wdata = '{tag: req_tag, valid: 1'b1, dirty: 1'b1};
    lru_we     = 1'b0;
    lru_way    = !way_q;
    hit        = 1'b0;
    miss       = 1'b0;

    bus.cpu_ready = 1'b0;
    bus.cpu_ack   = 1'b0;
    bus.cpu_rdata = '0;
    bus.da_index  = '0;
    bus.da_way    = 1'b0;
    bus.da_we     = 1'b0;
    bus.da_wdata  = '0;
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;

    unique case (state_q)
      IDLE: begin
        bus.cpu_ready = 1'b1;
        if (bus.cpu_req) begin
          we_d    = bus.cpu_we;
          addr_d  = bus.cpu_addr;
          wdata_d = bus.cpu_wdata;
          state_d = LOOKUP;
        end
      end

      LOOKUP: begin
        bus.da_index = req_index;
        bus.da_way   = sel_way;
        data_d       = bus.da_rdata;
        way_d        = sel_way;
        meta_way     = sel_way;
        hit          = lookup_hit;
        miss         = !lookup_hit;
        if (lookup_hit || (we_q && !victim_dirty)) begin
          // Write hit, or write miss into a clean victim: the line is fully written now.
          if (we_q) begin
            bus.da_we    = 1'b1;
            bus.da_wdata = wdata_q;
            meta_we      = 1'b1;
          end
          state_d = RESPOND;
        end else if (victim_dirty) begin
          state_d = WRITEBACK;
        end else begin
          state_d = FILL;
        end
      end

      WRITEBACK: begin
        bus.da_index  = req_index;
        bus.da_way    = way_q;
        bus.mem_req   = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_addr  = {rd_meta[way_q].tag, req_index};
        bus.mem_wdata = data_q;
        if (bus.mem_ack) begin
          if (we_q) begin
            bus.da_we    = 1'b1;
            bus.da_wdata = wdata_q;
            meta_we      = 1'b1;
            state_d      = RESPOND;
          end else begin
            state_d = FILL;
          end
        end
      end

      FILL: begin
        bus.da_index = req_index;
        bus.da_way   = way_q;
        bus.mem_req  = 1'b1;
        bus.mem_addr = addr_q;
        if (bus.mem_ack) begin
          bus.da_we        = 1'b1;
          bus.da_wdata     = bus.mem_rdata;
          meta_we          = 1'b1;
          meta_wdata.dirty = 1'b0;
          data_d           = bus.mem_rdata;
          state_d          = RESPOND;
        end
      end

      RESPOND: begin
        bus.cpu_ack   = 1'b1;
        bus.cpu_rdata = data_q;
        lru_we        = 1'b1;
        state_d       = IDLE;
      end

      default: state_d = IDLE;
    endcase

    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (hit && hit_cnt_q != 8'hFF)   hit_cnt_d  = hit_cnt_q + 8'd1;
    if (miss && miss_cnt_q != 8'hFF) miss_cnt_d = miss_cnt_q + 8'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      data_q     <= '0;
      way_q      <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      data_q     <= data_d;
      way_q      <= way_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;

endmodule

// File: tb/tb_cache_ctrl.sv
// Scoreboard bench for cache_ctrl: directed accesses push expected CPU, lookup
// and memory transactions; independent monitors pop and compare them.
module tb_cache_ctrl;

  typedef struct {
    logic [7:0] rdata;
    bit         chk_rdata;
    bit         chk_lat;
    int         issue;
  } cpu_exp_t;

  typedef struct {
    bit         we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
  } mem_exp_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       hit, miss;
  logic [7:0] hit_count, miss_count;

  cache_ctrl_if bus ();

  cache_ctrl dut (
    .clock      (clock),
    .reset      (reset),
    .bus        (bus),
    .hit        (hit),
    .miss       (miss),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  always #5 clock = ~clock;

  int checks    = 0;
  int failures  = 0;
  int cyc       = 0;
  int mem_stall = 1;

  cpu_exp_t cpu_q[$];
  mem_exp_t mem_q[$];
  bit       hm_q[$];

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    failures++;
    $display("FAIL %s: got unexpected/timeout required expected event", name);
  endtask

  // Data array: combinational read, write on the clock edge.
  logic [7:0] da_mem [8][2];
  assign bus.da_rdata = da_mem[bus.da_index][bus.da_way];
  always @(posedge clock) if (bus.da_we) da_mem[bus.da_index][bus.da_way] <= bus.da_wdata;

  // Memory responder and checker.
  initial begin
    bit       busy = 0;
    int       left = 0;
    mem_exp_t cur;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clock);
      if (reset) begin
        busy        = 0;
        bus.mem_ack = 1'b0;
      end else begin
        if (bus.mem_ack) begin
          bus.mem_ack = 1'b0;
        end else if (busy) begin
          check("mem_req_hold", bus.mem_req, 1);
          check("mem_addr_hold", bus.mem_addr, cur.addr);
          if (left == 0) begin
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = cur.rdata;
            busy          = 0;
          end else begin
            left--;
          end
        end
        if (!busy && !bus.mem_ack && bus.mem_req) begin
          if (mem_q.size() == 0) begin
            flag("mem_unexpected_req");
            cur = '{we: bus.mem_we, addr: bus.mem_addr, wdata: bus.mem_wdata, rdata: 8'h00};
          end else begin
            cur = mem_q.pop_front();
            check("mem_we", bus.mem_we, cur.we);
            check("mem_addr", bus.mem_addr, cur.addr);
            if (cur.we) check("mem_wdata", bus.mem_wdata, cur.wdata);
          end
          left = mem_stall;
          busy = 1;
        end
      end
    end
  end

  // CPU completion monitor.
  always @(negedge clock) begin
    if (bus.cpu_ack) begin
      if (cpu_q.size() == 0) begin
        flag("unexpected_cpu_ack");
      end else begin
        cpu_exp_t e;
        e = cpu_q.pop_front();
        if (e.chk_rdata) check("cpu_rdata", bus.cpu_rdata, e.rdata);
        if (e.chk_lat)   check("ack_latency", cyc - e.issue, 2);
      end
    end
  end

  // Lookup outcome monitor.
  always @(negedge clock) begin
    if (hit || miss) begin
      check("hit_miss_exclusive", {31'b0, hit && miss}, 0);
      if (hm_q.size() == 0) begin
        flag("unexpected_lookup");
      end else begin
        bit e;
        e = hm_q.pop_front();
        check("lookup_hit", hit, e);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "simulation did not finish");
  end

  task automatic cpu_access(input bit we, input logic [7:0] addr, input logic [7:0] wdata,
                            input bit exp_hit, input logic [7:0] exp_rdata, input bit want_ack);
    int       n = 0;
    cpu_exp_t e;
    @(negedge clock);
    while (!bus.cpu_ready && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (!bus.cpu_ready) begin
      flag("cpu_ready_timeout");
      return;
    end
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = we;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wdata;
    hm_q.push_back(exp_hit);
    if (want_ack) begin
      e.rdata     = exp_rdata;
      e.chk_rdata = !we;
      e.chk_lat   = exp_hit;
      e.issue     = cyc;
      cpu_q.push_back(e);
    end
    @(negedge clock);
    bus.cpu_req = 1'b0;
  endtask

  task automatic rd(input logic [7:0] addr, input bit exp_hit, input logic [7:0] exp_rdata);
    cpu_access(1'b0, addr, 8'h00, exp_hit, exp_rdata, 1'b1);
  endtask

  task automatic wr(input logic [7:0] addr, input logic [7:0] wdata, input bit exp_hit);
    cpu_access(1'b1, addr, wdata, exp_hit, 8'h00, 1'b1);
  endtask

  task automatic exp_wb(input logic [7:0] addr, input logic [7:0] wdata);
    mem_q.push_back('{we: 1'b1, addr: addr, wdata: wdata, rdata: 8'h00});
  endtask

  task automatic exp_fill(input logic [7:0] addr, input logic [7:0] rdata);
    mem_q.push_back('{we: 1'b0, addr: addr, wdata: 8'h00, rdata: rdata});
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(cpu_q.size() == 0 && mem_q.size() == 0 && hm_q.size() == 0 && bus.cpu_ready)
           && n < 500) begin
      @(negedge clock);
      n++;
    end
    if (n >= 500) flag("idle_timeout");
  endtask

  initial begin
    int n;
    bus.cpu_req   = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    check("reset_cpu_ready", bus.cpu_ready, 1);
    check("reset_cpu_ack", bus.cpu_ack, 0);
    check("reset_mem_req", bus.mem_req, 0);
    check("reset_da_we", bus.da_we, 0);
    check("reset_hit_miss", {hit, miss}, 0);
    check("reset_hit_count", hit_count, 0);
    check("reset_miss_count", miss_count, 0);

    exp_fill(8'h2A, 8'h5C);  rd(8'h2A, 0, 8'h5C);   // cold read miss
    rd(8'h2A, 1, 8'h5C);                            // read hit, no memory
    wr(8'h13, 8'hA1, 0);                            // write miss, no fill
    rd(8'h13, 1, 8'hA1);
    wr(8'h23, 8'hB2, 0);                            // fills way 1 of set 3, lru -> 0
    exp_wb(8'h13, 8'hA1); exp_fill(8'h33, 8'h77);
    rd(8'h33, 0, 8'h77);                            // dirty eviction of way 0
    exp_wb(8'h23, 8'hB2); exp_fill(8'h43, 8'h99);
    rd(8'h43, 0, 8'h99);                            // lru now names way 1
    rd(8'h33, 1, 8'h77);
    wr(8'h2A, 8'hEE, 1);                            // write hit sets dirty
    rd(8'h2A, 1, 8'hEE);
    wr(8'h6A, 8'h4D, 0);                            // set 2 way 1, lru -> 0
    exp_wb(8'h2A, 8'hEE);
    wr(8'h8A, 8'h8E, 0);                            // write miss over dirty victim
    rd(8'h8A, 1, 8'h8E);
    wait_idle();
    check("hit_count_mid", hit_count, 6);
    check("miss_count_mid", miss_count, 7);

    for (int i = 0; i < 300; i++) rd(8'h8A, 1, 8'h8E);
    wait_idle();
    check("hit_count_sat", hit_count, 8'hFF);
    check("miss_count_after_sat", miss_count, 7);

    // Reset while memory stalls a fill.
    mem_stall = 50;
    exp_fill(8'h50, 8'hDD);
    cpu_access(1'b0, 8'h50, 8'h00, 1'b0, 8'h00, 1'b0);
    n = 0;
    while (!bus.mem_req && n < 20) begin
      @(negedge clock);
      n++;
    end
    repeat (2) @(negedge clock);
    check("fill_req_stalled", bus.mem_req, 1);
    reset = 1'b1;
    @(negedge clock);
    check("rst_mem_req", bus.mem_req, 0);
    check("rst_cpu_ack", bus.cpu_ack, 0);
    check("rst_hit_count", hit_count, 0);
    check("rst_miss_count", miss_count, 0);
    @(negedge clock);
    reset = 1'b0;
    mem_stall = 1;
    @(negedge clock);
    check("post_rst_cpu_ready", bus.cpu_ready, 1);
    check("post_rst_mem_req", bus.mem_req, 0);

    exp_fill(8'h2A, 8'h3C);  rd(8'h2A, 0, 8'h3C);   // lines invalid: no writeback
    exp_fill(8'h8A, 8'h11);  rd(8'h8A, 0, 8'h11);
    wait_idle();
    check("final_hit_count", hit_count, 0);
    check("final_miss_count", miss_count, 2);
    check("cpu_q_empty", cpu_q.size(), 0);
    check("mem_q_empty", mem_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
